rmii_tx_arbiter: RTL and testbench

- Shares the single RMII transmit pair (eth_txen/eth_txd) between two free-running frame sources: the manta Ethernet core and the mac_tx streamer.
- Arbitration is frame-granular. A source requests, receives a grant, then transmits one frame; the arbiter muxes that source to the pins.
- The arbiter enforces the inter-frame gap, a grant-to-start timeout and a maximum frame length.
- It sits between the sources and the top-level eth_txen/eth_txd pins, in the 50 MHz RMII clock domain.

---
 rtl/rmii_arb_pkg.sv | 26 ++
 rtl/rmii_tx_arbiter_if.sv | 21 ++
 rtl/rr_pick2.sv | 21 ++
 rtl/rmii_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_rmii_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rmii_arb_pkg.sv
// Shared types and constants for the RMII transmit arbiter.
package rmii_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANTED,
        TX,
        DRAIN,
        IFG
    } state_e;

    localparam int SRC_MANTA = 0;
    localparam int SRC_MACTX = 1;

    localparam int DEF_IFG_CYCLES       = 48;
    localparam int DEF_GRANT_TIMEOUT    = 64;
    localparam int DEF_MAX_FRAME_CYCLES = 6120;

    localparam int CNT_W = 13;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rmii_tx_arbiter_if.sv
// Source-side request/grant and RMII pin bundle for the transmit arbiter.
interface rmii_tx_arbiter_if;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       src0_txen;
    logic [1:0] src0_txd;
    logic       src1_txen;
    logic [1:0] src1_txd;
    logic       eth_txen;
    logic [1:0] eth_txd;

    modport master (
        input  req, src0_txen, src0_txd, src1_txen, src1_txd,
        output gnt, eth_txen, eth_txd
    );

    modport slave (
        output req, src0_txen, src0_txd, src1_txen, src1_txd,
        input  gnt, eth_txen, eth_txd
    );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to the
// source that did not win last time.
module rr_pick2
    import rmii_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       win_o
);

    always_comb begin
        valid_o = |req_i;
        if (&req_i) begin
            win_o = ~last_i;
        end else begin
            win_o = req_i[SRC_MACTX];
        end
    end

endmodule

// File: rtl/rmii_tx_arbiter.sv
// Frame-granular arbiter sharing one RMII transmit pair between two sources,
// with inter-frame gap, grant timeout and frame-length enforcement.
module rmii_tx_arbiter
    import rmii_arb_pkg::*;
#(
    parameter int IFG_CYCLES       = DEF_IFG_CYCLES,
    parameter int GRANT_TIMEOUT    = DEF_GRANT_TIMEOUT,
    parameter int MAX_FRAME_CYCLES = DEF_MAX_FRAME_CYCLES
) (
    input  logic              clk,
    input  logic              rstn,
    rmii_tx_arbiter_if.master bus,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overlong,
    output logic [15:0]       frames_sent
);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(GRANT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(MAX_FRAME_CYCLES);

    state_e           state_q;
    logic [1:0]       gnt_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             eth_txen_q;
    logic [1:0]       eth_txd_q;
    logic             err_to_q;
    logic             err_ol_q;
    logic [15:0]      frames_q;

    logic             pick_vld;
    logic             pick_win;
    logic             txen_g;
    logic [1:0]       txd_g;
    logic             req_g;

    rr_pick2 u_pick (
        .req_i   (bus.req),
        .last_i  (last_q),
        .valid_o (pick_vld),
        .win_o   (pick_win)
    );

    // last_q doubles as the index of the currently granted source.
    always_comb begin
        if (last_q == 1'(SRC_MACTX)) begin
            txen_g = bus.src1_txen;
            txd_g  = bus.src1_txd;
            req_g  = bus.req[SRC_MACTX];
        end else begin
            txen_g = bus.src0_txen;
            txd_g  = bus.src0_txd;
            req_g  = bus.req[SRC_MANTA];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            last_q     <= 1'(SRC_MACTX);
            cnt_q      <= '0;
            eth_txen_q <= 1'b0;
            eth_txd_q  <= 2'b00;
            err_to_q   <= 1'b0;
            err_ol_q   <= 1'b0;
            frames_q   <= 16'd0;
        end else begin
            err_to_q   <= 1'b0;
            err_ol_q   <= 1'b0;
            eth_txen_q <= 1'b0;
            eth_txd_q  <= 2'b00;
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q   <= pick_win ? 2'b10 : 2'b01;
                        last_q  <= pick_win;
                        cnt_q   <= '0;
                        state_q <= GRANTED;
                    end
                end
                GRANTED: begin
                    eth_txen_q <= txen_g;
                    eth_txd_q  <= txd_g;
                    if (txen_g) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= TX;
                    end else if (!req_g) begin
                        gnt_q   <= 2'b00;
                        state_q <= IDLE;
                    end else if (cnt_q >= TO_LAST) begin
                        err_to_q <= 1'b1;
                        gnt_q    <= 2'b00;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                TX: begin
                    if (!txen_g) begin
                        eth_txd_q <= txd_g;
                        gnt_q     <= 2'b00;
                        frames_q  <= frames_q + 16'd1;
                        cnt_q     <= '0;
                        state_q   <= IFG;
                    end else if (cnt_q >= MAX_LEN) begin
                        // Truncate: pins already forced low by the defaults above.
                        err_ol_q <= 1'b1;
                        gnt_q    <= 2'b00;
                        state_q  <= DRAIN;
                    end else begin
                        eth_txen_q <= 1'b1;
                        eth_txd_q  <= txd_g;
                        cnt_q      <= sat_inc(cnt_q);
                    end
                end
                DRAIN: begin
                    if (!txen_g) begin
                        cnt_q   <= '0;
                        state_q <= IFG;
                    end
                end
                IFG: begin
                    if (cnt_q >= IFG_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.eth_txen = eth_txen_q;
    assign bus.eth_txd  = eth_txd_q;
    assign busy         = (state_q != IDLE);
    assign err_timeout  = err_to_q;
    assign err_overlong = err_ol_q;
    assign frames_sent  = frames_q;

endmodule

// File: tb/tb_rmii_tx_arbiter.sv
// Directed-sequence bench with randomized frame contents, lengths and start
// delays, checked against a rule-level reference model.
module tb_rmii_tx_arbiter;

    localparam int IFG  = 48;
    localparam int GTO  = 64;
    localparam int MAXF = 200;

    logic        clk = 1'b0;
    logic        rstn;
    logic        busy;
    logic        err_timeout;
    logic        err_overlong;
    logic [15:0] frames_sent;

    int checks   = 0;
    int failures = 0;
    int mdl_frames;
    int mdl_last;
    int win;

    rmii_tx_arbiter_if bus ();

    rmii_tx_arbiter #(
        .IFG_CYCLES       (IFG),
        .GRANT_TIMEOUT    (GTO),
        .MAX_FRAME_CYCLES (MAXF)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_overlong (err_overlong),
        .frames_sent  (frames_sent)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_src(input int src, input logic en, input logic [1:0] d);
        if (src == 0) begin
            bus.src0_txen = en;
            bus.src0_txd  = d;
        end else begin
            bus.src1_txen = en;
            bus.src1_txd  = d;
        end
    endtask

    function automatic logic [1:0] onehot(input int s);
        return (s == 1) ? 2'b10 : 2'b01;
    endfunction

    // Lone requester wins; a tie goes to whoever did not win last.
    function automatic int rr_model(input logic [1:0] r, input int last);
        if (r == 2'b11) return (last == 0) ? 1 : 0;
        return (r == 2'b10) ? 1 : 0;
    endfunction

    task automatic wait_grant(input logic [1:0] exp_oh, input int exp_n);
        int n = 0;
        while (bus.gnt == 2'b00 && n < 200) begin
            tick();
            n++;
        end
        chk("grant_onehot", 32'(bus.gnt), 32'(exp_oh));
        chk("grant_wait", 32'(n), 32'(exp_n));
    endtask

    task automatic request(input logic [1:0] r, input int exp_n, output int w);
        bus.req  = r;
        w        = rr_model(r, mdl_last);
        mdl_last = w;
        wait_grant(onehot(w), exp_n);
    endtask

    task automatic send_frame(input int src, input int pre, input int len, input bit rogue);
        logic [1:0] oh;
        logic [1:0] d;
        logic       en;
        logic       exp_en;
        int         ov;
        int         to_p;
        int         oth;
        oh   = onehot(src);
        oth  = 1 - src;
        ov   = 0;
        to_p = 0;
        for (int i = 0; i < pre; i++) begin
            drive_src(src, 1'b0, 2'b00);
            if (rogue) drive_src(oth, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            tick();
            chk("pre_txen", 32'(bus.eth_txen), 32'd0);
            chk("pre_gnt", 32'(bus.gnt), 32'(oh));
        end
        for (int i = 0; i <= len; i++) begin
            en = (i < len);
            d  = en ? 2'($urandom_range(0, 3)) : 2'b00;
            drive_src(src, en, d);
            if (rogue) drive_src(oth, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            tick();
            exp_en = en && (i < MAXF);
            chk("tx_txen", 32'(bus.eth_txen), 32'(exp_en));
            chk("tx_txd", 32'(bus.eth_txd), exp_en ? 32'(d) : 32'd0);
            chk("tx_gnt", 32'(bus.gnt), exp_en ? 32'(oh) : 32'd0);
            if (en && i >= MAXF) chk("drain_busy", 32'(busy), 32'd1);
            if (err_overlong) ov++;
            if (err_timeout) to_p++;
        end
        if (rogue) drive_src(oth, 1'b0, 2'b00);
        chk("overlong_pulses", 32'(ov), (len > MAXF) ? 32'd1 : 32'd0);
        chk("frame_timeout_pulses", 32'(to_p), 32'd0);
        chk("ifg_busy", 32'(busy), 32'd1);
        if (len <= MAXF) mdl_frames = (mdl_frames + 1) % 65536;
        chk("frames_sent", 32'(frames_sent), 32'(mdl_frames));
    endtask

    initial begin
        int n;
        int eth_hi;
        rstn       = 1'b0;
        bus.req    = 2'b00;
        drive_src(0, 1'b0, 2'b00);
        drive_src(1, 1'b0, 2'b00);
        mdl_frames = 0;
        mdl_last   = 1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_txen", 32'(bus.eth_txen), 32'd0);
        chk("rst_txd", 32'(bus.eth_txd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        chk("rst_err_overlong", 32'(err_overlong), 32'd0);
        chk("rst_frames", 32'(frames_sent), 32'd0);
        rstn = 1'b1;
        tick();

        // Ungranted source transmitting while idle must not reach the pins.
        for (int i = 0; i < 5; i++) begin
            drive_src(1, 1'b1, 2'($urandom_range(0, 3)));
            tick();
            chk("idle_rogue_txen", 32'(bus.eth_txen), 32'd0);
            chk("idle_rogue_gnt", 32'(bus.gnt), 32'd0);
        end
        drive_src(1, 1'b0, 2'b00);

        // Single frame, then IFG-gated re-grant, then withdrawal.
        request(2'b01, 1, win);
        send_frame(win, 3, 100, 1'b0);
        request(2'b01, IFG + 1, win);
        bus.req = 2'b00;
        tick();
        chk("withdraw_gnt", 32'(bus.gnt), 32'd0);
        chk("withdraw_busy", 32'(busy), 32'd0);
        chk("withdraw_frames", 32'(frames_sent), 32'(mdl_frames));

        // Contention: both requesting, grants must alternate.
        for (int f = 0; f < 4; f++) begin
            request(2'b11, (f == 0) ? 1 : IFG + 1, win);
            send_frame(win, $urandom_range(0, 5), (f < 2) ? 20 : $urandom_range(8, 40), 1'b0);
        end
        bus.req = 2'b00;
        repeat (IFG + 2) tick();
        chk("contention_idle", 32'(busy), 32'd0);

        // Timeout: granted source never transmits.
        request(2'b10, 1, win);
        n      = 0;
        eth_hi = 0;
        while (err_timeout !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (bus.eth_txen) eth_hi++;
        end
        bus.req = 2'b00;
        chk("timeout_latency", 32'(n), 32'(GTO));
        chk("timeout_gnt", 32'(bus.gnt), 32'd0);
        chk("timeout_eth_hi", 32'(eth_hi), 32'd0);
        tick();
        chk("timeout_pulse_end", 32'(err_timeout), 32'd0);
        chk("timeout_frames", 32'(frames_sent), 32'(mdl_frames));

        // Overlong: truncation, drain, then IFG before the next grant.
        request(2'b01, 1, win);
        send_frame(win, 2, 300, 1'b0);
        request(2'b01, IFG + 1, win);
        bus.req = 2'b00;
        tick();
        chk("overlong_withdraw_gnt", 32'(bus.gnt), 32'd0);

        // Rogue src1 toggling during a src0 frame.
        request(2'b01, 1, win);
        send_frame(win, 1, $urandom_range(30, 60), 1'b1);
        bus.req = 2'b00;
        repeat (IFG + 2) tick();

        // Asynchronous reset in the middle of a frame.
        request(2'b01, 1, win);
        for (int i = 0; i < 10; i++) begin
            drive_src(0, 1'b1, 2'($urandom_range(0, 3)));
            tick();
        end
        chk("midframe_txen", 32'(bus.eth_txen), 32'd1);
        #5;
        rstn = 1'b0;
        #1;
        chk("async_txen", 32'(bus.eth_txen), 32'd0);
        chk("async_gnt", 32'(bus.gnt), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        drive_src(0, 1'b0, 2'b00);
        bus.req    = 2'b10;
        mdl_frames = 0;
        mdl_last   = 1;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tick();
        chk("post_reset_gnt", 32'(bus.gnt), 32'(onehot(rr_model(2'b10, mdl_last))));
        chk("post_reset_frames", 32'(frames_sent), 32'(mdl_frames));
        bus.req = 2'b00;
        tick();
        chk("post_reset_withdraw", 32'(bus.gnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
